// File: rtl/count_run_arbiter.sv
// Round-robin arbiter for two requesters sharing one external 4-bit up-counter.
// Optional RUN-phase watchdog abort is compiled in with COUNT_WATCHDOG_EN.
module count_run_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  input  logic [3:0] cnt_val,
  output logic       cnt_clr,
  output logic       cnt_en,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       busy,
  output logic       err
);

  localparam int unsigned LEN_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             owner_q, owner_d;
  logic             prio_q, prio_d;
  logic             clr_q, clr_d;
  logic             busy_q, busy_d;
  logic             win;
  logic             owner_req;
  logic             match;

`ifdef COUNT_WATCHDOG_EN
  localparam int unsigned WD_W = 5;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(16);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  // Favoured requester wins a tie; otherwise the lone requester wins.
  assign win       = (req0 && req1) ? prio_q : req1;
  assign owner_req = owner_q ? req1 : req0;
  assign match     = (cnt_val == len_q);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    len_d   = len_q;
    owner_d = owner_q;
    prio_d  = prio_q;
`ifdef COUNT_WATCHDOG_EN
    wd_d    = '0;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d = win;
          len_d   = win ? len1 : len0;
          gnt_d   = win ? 2'b10 : 2'b01;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (!owner_req) begin
          gnt_d   = 2'b00;
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!owner_req) begin
          gnt_d   = 2'b00;
          state_d = S_IDLE;
        end else if (match) begin
          gnt_d   = 2'b00;
          done_d  = owner_q ? 2'b10 : 2'b01;
          state_d = S_DONE;
        end
`ifdef COUNT_WATCHDOG_EN
        else if (wd_q == WD_LAST) begin
          gnt_d   = 2'b00;
          err_d   = 1'b1;
          prio_d  = ~owner_q;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      S_DONE: begin
        prio_d  = ~owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    clr_d  = (state_d == S_CLEAR);
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      len_q   <= '0;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef COUNT_WATCHDOG_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      len_q   <= len_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
`ifdef COUNT_WATCHDOG_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  // Increment must stop in the very cycle the counter reaches the terminal value.
  assign cnt_en  = (state_q == S_RUN) && !match;
  assign cnt_clr = clr_q;
  assign gnt0    = gnt_q[0];
  assign gnt1    = gnt_q[1];
  assign done0   = done_q[0];
  assign done1   = done_q[1];
  assign busy    = busy_q;
`ifdef COUNT_WATCHDOG_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule
